// File: rtl/hazard_stall_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | hazard_stall_unit: decode-stage load-use / branch-on-load / memory-wait   |
// | hazard control with stall counters and sticky memory timeout fault.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module hazard_stall_unit #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    src1D,
  input  logic [2:0]    src2D,
  input  logic          useSrc1D,
  input  logic          useSrc2D,
  input  logic          isBranchD,
  input  logic [2:0]    branchRegD,
  input  logic          branchTakenD,
  input  logic [2:0]    destAfterD2E,
  input  logic          RWAfterD2E,
  input  logic          MTRAfterD2E,
  input  logic [2:0]    EX_MEM_RD,
  input  logic          RWAfterE2M,
  input  logic          MTRAfterE2M,
  input  logic          memReq,
  input  logic          memReady,
  output logic          stallPC,
  output logic          stallF2D,
  output logic          bubbleD2E,
  output logic          flushF2D,
  output logic          freeze,
  output logic          memFault,
  output logic [CW-1:0] loadStallCnt,
  output logic [CW-1:0] branchStallCnt,
  output logic [CW-1:0] freezeCnt
);

  localparam int c_ww = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [c_ww-1:0] c_timeout = c_ww'(TIMEOUT);

  typedef enum logic [0:0] {IDLE = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [c_ww-1:0] wait_q, wait_d;
  logic            fault_q, fault_d;
  logic [CW-1:0]   load_cnt_q, br_cnt_q, frz_cnt_q;

  logic w_loadUse, w_brLoad, w_hazard, w_memStall;

  assign w_loadUse = MTRAfterD2E & RWAfterD2E &
                     ((useSrc1D & (src1D == destAfterD2E)) |
                      (useSrc2D & (src2D == destAfterD2E)));
  assign w_brLoad  = isBranchD &
                     ((MTRAfterD2E & RWAfterD2E & (branchRegD == destAfterD2E)) |
                      (MTRAfterE2M & RWAfterE2M & (branchRegD == EX_MEM_RD)));
  assign w_hazard   = w_loadUse | w_brLoad;
  assign w_memStall = memReq & ~memReady & ~fault_q;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    fault_d   = fault_q;
    freeze    = 1'b0;
    stallPC   = 1'b0;
    stallF2D  = 1'b0;
    bubbleD2E = 1'b0;
    flushF2D  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_memStall) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = c_ww'(1);
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          freeze  = 1'b1;
          state_d = IDLE;
        end else if (wait_q == c_timeout) begin
          // Give up: release the pipeline and latch the fault.
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          freeze = 1'b1;
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!freeze) begin
      if (w_hazard) begin
        stallPC   = 1'b1;
        stallF2D  = 1'b1;
        bubbleD2E = 1'b1;
      end else if (branchTakenD) begin
        flushF2D = 1'b1;
      end
    end
    if (rst) begin
      freeze    = 1'b0;
      stallPC   = 1'b0;
      stallF2D  = 1'b0;
      bubbleD2E = 1'b0;
      flushF2D  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      fault_q    <= 1'b0;
      load_cnt_q <= '0;
      br_cnt_q   <= '0;
      frz_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      if (stallPC && w_loadUse && (load_cnt_q != '1))
        load_cnt_q <= load_cnt_q + 1'b1;
      if (stallPC && w_brLoad && !w_loadUse && (br_cnt_q != '1))
        br_cnt_q <= br_cnt_q + 1'b1;
      if (freeze && (frz_cnt_q != '1))
        frz_cnt_q <= frz_cnt_q + 1'b1;
    end
  end

  assign memFault       = fault_q;
  assign loadStallCnt   = load_cnt_q;
  assign branchStallCnt = br_cnt_q;
  assign freezeCnt      = frz_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_hazard_stall_unit: directed vector table plus multi-cycle sequences.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_hazard_stall_unit;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] src1D = '0, src2D = '0, branchRegD = '0, destAfterD2E = '0, EX_MEM_RD = '0;
  logic useSrc1D = 0, useSrc2D = 0, isBranchD = 0, branchTakenD = 0;
  logic RWAfterD2E = 0, MTRAfterD2E = 0, RWAfterE2M = 0, MTRAfterE2M = 0;
  logic memReq = 0, memReady = 0;
  logic stallPC, stallF2D, bubbleD2E, flushF2D, freeze, memFault;
  logic [CW-1:0] loadStallCnt, branchStallCnt, freezeCnt;

  int nvec = 0;
  int nfail = 0;

  hazard_stall_unit #(.TIMEOUT(4), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .src1D(src1D), .src2D(src2D), .useSrc1D(useSrc1D), .useSrc2D(useSrc2D),
    .isBranchD(isBranchD), .branchRegD(branchRegD), .branchTakenD(branchTakenD),
    .destAfterD2E(destAfterD2E), .RWAfterD2E(RWAfterD2E), .MTRAfterD2E(MTRAfterD2E),
    .EX_MEM_RD(EX_MEM_RD), .RWAfterE2M(RWAfterE2M), .MTRAfterE2M(MTRAfterE2M),
    .memReq(memReq), .memReady(memReady),
    .stallPC(stallPC), .stallF2D(stallF2D), .bubbleD2E(bubbleD2E),
    .flushF2D(flushF2D), .freeze(freeze), .memFault(memFault),
    .loadStallCnt(loadStallCnt), .branchStallCnt(branchStallCnt), .freezeCnt(freezeCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s1, s2;
    logic       u1, u2, br;
    logic [2:0] brr;
    logic       tk;
    logic [2:0] dd;
    logic       rwd, mtrd;
    logic [2:0] de;
    logic       rwe, mtre;
    logic       e_stall, e_flush;
  } vec_t;

  vec_t tbl[13];

  task automatic chk1(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkc(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    src1D = v.s1; src2D = v.s2; useSrc1D = v.u1; useSrc2D = v.u2;
    isBranchD = v.br; branchRegD = v.brr; branchTakenD = v.tk;
    destAfterD2E = v.dd; RWAfterD2E = v.rwd; MTRAfterD2E = v.mtrd;
    EX_MEM_RD = v.de; RWAfterE2M = v.rwe; MTRAfterE2M = v.mtre;
  endtask

  task automatic clear_in();
    vec_t z;
    z = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    apply(z);
    memReq = 1'b0; memReady = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string nm, input logic st, input logic fl, input logic fz);
    chk1({nm, ".stallPC"}, stallPC, st);
    chk1({nm, ".stallF2D"}, stallF2D, st);
    chk1({nm, ".bubbleD2E"}, bubbleD2E, st);
    chk1({nm, ".flushF2D"}, flushF2D, fl);
    chk1({nm, ".freeze"}, freeze, fz);
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  task automatic count_freeze(output logic [CW-1:0] n);
    n = '0;
    while (freeze && n < 16'd20) begin
      n++;
      @(posedge clk);
      #2;
    end
  endtask

  logic [CW-1:0] nf;

  initial begin
    //           s1    s2    u1 u2 br brr   tk dd    rwd mtrd de   rwe mtre stall flush
    tbl[0]  = '{3'd3, 3'd2, 1, 0, 0, 3'd0, 0, 3'd3, 1, 1, 3'd0, 0, 0, 1, 0}; // src1 load-use
    tbl[1]  = '{3'd3, 3'd2, 0, 0, 0, 3'd0, 0, 3'd3, 1, 1, 3'd0, 0, 0, 0, 0}; // src not read
    tbl[2]  = '{3'd1, 3'd3, 1, 1, 0, 3'd0, 0, 3'd3, 1, 1, 3'd0, 0, 0, 1, 0}; // src2 load-use
    tbl[3]  = '{3'd3, 3'd2, 1, 1, 0, 3'd0, 0, 3'd3, 1, 0, 3'd0, 0, 0, 0, 0}; // ALU writer
    tbl[4]  = '{3'd3, 3'd2, 1, 1, 0, 3'd0, 0, 3'd3, 0, 1, 3'd0, 0, 0, 0, 0}; // no reg write
    tbl[5]  = '{3'd0, 3'd0, 0, 0, 1, 3'd5, 0, 3'd5, 1, 1, 3'd0, 0, 0, 1, 0}; // br on D2E load
    tbl[6]  = '{3'd0, 3'd0, 0, 0, 1, 3'd5, 0, 3'd0, 0, 0, 3'd5, 1, 1, 1, 0}; // br on E2M load
    tbl[7]  = '{3'd0, 3'd0, 0, 0, 1, 3'd5, 0, 3'd0, 0, 0, 3'd5, 1, 0, 0, 0}; // br on E2M ALU
    tbl[8]  = '{3'd0, 3'd0, 0, 0, 1, 3'd5, 0, 3'd5, 1, 0, 3'd0, 0, 0, 0, 0}; // br on D2E ALU
    tbl[9]  = '{3'd1, 3'd2, 1, 1, 1, 3'd1, 1, 3'd4, 1, 1, 3'd4, 1, 1, 0, 1}; // taken, no hazard
    tbl[10] = '{3'd3, 3'd2, 1, 0, 0, 3'd0, 1, 3'd3, 1, 1, 3'd0, 0, 0, 1, 0}; // taken + load-use
    tbl[11] = '{3'd3, 3'd2, 1, 0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd3, 1, 1, 0, 0}; // E2M load, non-branch
    tbl[12] = '{3'd0, 3'd0, 0, 0, 0, 3'd5, 0, 3'd0, 0, 0, 3'd5, 1, 1, 0, 0}; // not a branch

    // Reset state, with hazard inputs present while rst is high
    apply(tbl[0]); branchTakenD = 1'b1; memReq = 1'b1;
    #2;
    chk_ctl("rst_hold", 1'b0, 1'b0, 1'b0);
    chk1("rst.memFault", memFault, 1'b0);
    chkc("rst.loadStallCnt", loadStallCnt, '0);
    do_reset();

    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1;
      chk_ctl($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_flush, 1'b0);
      nxt();
    end
    clear_in();
    #1;
    chkc("tbl.loadStallCnt", loadStallCnt, 16'd3);
    chkc("tbl.branchStallCnt", branchStallCnt, 16'd2);

    // Load-use lasts one cycle; taken branch blocked then honoured
    do_reset();
    destAfterD2E = 3'd3; RWAfterD2E = 1; MTRAfterD2E = 1; src1D = 3'd3; useSrc1D = 1;
    branchTakenD = 1;
    #1; chk_ctl("lu.c1", 1'b1, 1'b0, 1'b0);
    nxt();
    RWAfterD2E = 0; MTRAfterD2E = 0; destAfterD2E = 3'd0;
    EX_MEM_RD = 3'd3; RWAfterE2M = 1; MTRAfterE2M = 1;
    #1; chk_ctl("lu.c2", 1'b0, 1'b1, 1'b0);
    nxt();
    branchTakenD = 0;
    #1; chk_ctl("lu.c3", 1'b0, 1'b0, 1'b0);
    chkc("lu.loadStallCnt", loadStallCnt, 16'd1);

    // Branch on load: two stall cycles; on ALU result: none
    do_reset();
    isBranchD = 1; branchRegD = 3'd5;
    destAfterD2E = 3'd5; RWAfterD2E = 1; MTRAfterD2E = 1;
    #1; chk_ctl("bl.c1", 1'b1, 1'b0, 1'b0);
    nxt();
    RWAfterD2E = 0; MTRAfterD2E = 0; destAfterD2E = 3'd0;
    EX_MEM_RD = 3'd5; RWAfterE2M = 1; MTRAfterE2M = 1;
    #1; chk_ctl("bl.c2", 1'b1, 1'b0, 1'b0);
    nxt();
    RWAfterE2M = 0; MTRAfterE2M = 0; EX_MEM_RD = 3'd0;
    #1; chk_ctl("bl.c3", 1'b0, 1'b0, 1'b0);
    chkc("bl.branchStallCnt", branchStallCnt, 16'd2);
    destAfterD2E = 3'd5; RWAfterD2E = 1;
    #1; chk_ctl("ba.c1", 1'b0, 1'b0, 1'b0);
    nxt();
    RWAfterD2E = 0; destAfterD2E = 3'd0; EX_MEM_RD = 3'd5; RWAfterE2M = 1;
    #1; chk_ctl("ba.c2", 1'b0, 1'b0, 1'b0);
    nxt();
    chkc("ba.branchStallCnt", branchStallCnt, 16'd2);

    // Memory wait: immediate ready, then ready on third cycle; hazard masked
    do_reset();
    memReq = 1; memReady = 1;
    #1; chk_ctl("mem.instant", 1'b0, 1'b0, 1'b0);
    nxt();
    memReady = 0;
    destAfterD2E = 3'd3; RWAfterD2E = 1; MTRAfterD2E = 1; src1D = 3'd3; useSrc1D = 1;
    #1; chk_ctl("mem.c0", 1'b0, 1'b0, 1'b1);
    nxt();
    memReq = 0;
    #1; chk_ctl("mem.c1", 1'b0, 1'b0, 1'b1);
    nxt();
    memReady = 1;
    #1; chk_ctl("mem.c2", 1'b0, 1'b0, 1'b1);
    nxt();
    memReady = 0;
    #1; chk_ctl("mem.release", 1'b1, 1'b0, 1'b0);
    chkc("mem.freezeCnt", freezeCnt, 16'd3);

    // Timeout: four freeze cycles, then sticky fault masks further requests
    do_reset();
    memReq = 1;
    #1;
    count_freeze(nf);
    chkc("to.freeze_cycles", nf, 16'd4);
    nxt();
    #1;
    chk1("to.memFault", memFault, 1'b1);
    chk1("to.no_refreeze", freeze, 1'b0);
    nxt();
    #1;
    chk1("to.still_no_freeze", freeze, 1'b0);
    chkc("to.freezeCnt", freezeCnt, 16'd4);

    // Asynchronous reset in the middle of a memory wait
    do_reset();
    memReq = 1;
    nxt();
    nxt();
    destAfterD2E = 3'd3; RWAfterD2E = 1; MTRAfterD2E = 1; src1D = 3'd3; useSrc1D = 1;
    #1;
    rst = 1'b1;
    #1;
    chk_ctl("arst", 1'b0, 1'b0, 1'b0);
    chkc("arst.freezeCnt", freezeCnt, '0);
    nxt();
    rst = 1'b0;
    useSrc1D = 0;
    #1;
    count_freeze(nf);
    chkc("arst.restart_cycles", nf, 16'd4);
    nxt();
    #1;
    chk1("arst.memFault", memFault, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
